inv_mix_columns_seq: RTL and testbench

- Sequences one shared single-column InvMixColumns datapath across the four columns of a 128-bit AES state, one column per clock.
- The datapath is built from the team's GF constant multipliers (x9, xB, xD, xE).
- Sits in the decryption round pipeline between InvSubBytes/InvShiftRows/AddRoundKey and the round register.
- Uses a valid/ready handshake on both sides. A bypass mode serves the final round, which has no InvMixColumns.

---
 rtl/inv_mix_columns_seq.sv | 145 ++++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: one shared single-column datapath is
// stepped across the four columns of a 128-bit state, one column per clock,
// with valid/ready on both sides and a pass-through mode for the final round.
module inv_mix_columns_seq #(
  parameter int NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass_in,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   col_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  state_t            state, state_nxt;
  logic [3:0][31:0]  work;       // column 0 sits in work[3] (most significant word)
  logic [3:0][31:0]  work_nxt;
  logic [31:0]       col_in;
  logic [31:0]       col_out;
  logic              byp;
  logic              acc;
  logic              last;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // One column through the inverse mixing matrix; row 0 is the top byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    return {b0, b1, b2, b3};
  endfunction

  assign acc  = (state == IDLE) && in_valid && !clear;
  assign last = (state == CALC) && (col_idx == LAST_COL);

  // Datapath: transform the selected column and splice it back into the state
  always_comb begin
    work_nxt           = work;
    col_in             = work[~col_idx];
    col_out            = byp ? col_in : inv_mix_col(col_in);
    work_nxt[~col_idx] = col_out;
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides every handshake
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)  state_nxt = CALC;
        CALC:    if (last)      state_nxt = HOLD;
        HOLD:    if (out_ready) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // FSM-decoded outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == CALC) || (state == HOLD);
  end

  // Control registers: column counter, output valid, bypass flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_idx   <= 2'd0;
      out_valid <= 1'b0;
      byp       <= 1'b0;
    end else if (clear) begin
      col_idx   <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (acc) begin
        col_idx <= 2'd0;
        byp     <= bypass_in;
      end else if (state == CALC) begin
        col_idx <= col_idx + 2'd1;
      end
      if (last)                           out_valid <= 1'b1;
      else if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

  // Work register and result register; state_out is only refreshed on completion
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work      <= '0;
      state_out <= '0;
    end else if (!clear) begin
      if (acc)                work <= state_in;
      else if (state == CALC) work <= work_nxt;
      if (last)               state_out <= work_nxt;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: fixed and random states checked
// against a matrix-form InvMixColumns model, plus handshake and abort scenarios.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass_in;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
  logic [1:0]   col_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [127:0] last_exp = '0;

  inv_mix_columns_seq #(.NUM_COLS(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .bypass_in (bypass_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy),
    .col_idx   (col_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generic shift-and-add multiply in GF(2^8)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Whole-state InvMixColumns: circulant matrix with first row {0e,0b,0d,09}
  function automatic logic [127:0] model_inv_mix(input logic [127:0] s, input bit byp);
    logic [7:0]   a [16];
    logic [7:0]   m [4];
    logic [7:0]   accum;
    logic [127:0] res;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    if (byp) return s;
    for (int k = 0; k < 16; k++) a[k] = s[127-8*k -: 8];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        accum = 8'h00;
        for (int j = 0; j < 4; j++) accum = accum ^ gmul(m[(j - r + 4) % 4], a[4*c+j]);
        res[127-8*(4*c+r) -: 8] = accum;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; state_in = '0; bypass_in = 1'b0;
    clear = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || col_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b col=%0d want 1 0 0 0",
               in_ready, out_valid, busy, col_idx);
    end
    total++;
    if (state_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", state_out);
    end
    n_rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  // Fixed vectors, the bypass vector and random states, each with full timing checks
  task automatic test_vectors();
    logic [127:0] vin  [$];
    logic [127:0] vexp [$];
    bit           vbyp [$];
    logic [127:0] d;
    bit           b;
    vin.push_back(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    vexp.push_back(128'hdb135345_f20a225c_01010101_c6c6c6c6); vbyp.push_back(1'b0);
    vin.push_back(128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
    vexp.push_back(128'hd4d4d4d5_2d26314c_00000000_ffffffff); vbyp.push_back(1'b0);
    vin.push_back(128'h00112233_44556677_8899aabb_ccddeeff);
    vexp.push_back(128'h00112233_44556677_8899aabb_ccddeeff); vbyp.push_back(1'b1);
    for (int i = 0; i < 12; i++) begin
      d = rnd128();
      b = ($urandom_range(0, 3) == 0);
      vin.push_back(d); vexp.push_back(model_inv_mix(d, b)); vbyp.push_back(b);
    end
    for (int i = 0; i < vin.size(); i++) begin
      out_ready = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_ready: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1; state_in = vin[i]; bypass_in = vbyp[i];
      @(negedge clk);
      in_valid = 1'b0; state_in = rnd128(); bypass_in = ~vbyp[i];
      for (int k = 0; k < 4; k++) begin
        total++;
        if (col_idx !== 2'(k) || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL vec%0d_calc%0d: got col=%0d busy=%b vld=%b rdy=%b want col=%0d 1 0 0",
                   i, k, col_idx, busy, out_valid, in_ready, k);
        end
        @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b1 || state_out !== vexp[i] || col_idx !== 2'd0) begin
        bad++;
        $display("FAIL vec%0d_result: got vld=%b col=%0d %h want 1 0 %h",
                 i, out_valid, col_idx, state_out, vexp[i]);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_done: got vld=%b rdy=%b busy=%b want 0 1 0", i, out_valid, in_ready, busy);
      end
      last_exp = vexp[i];
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, e;
    d = rnd128();
    e = model_inv_mix(d, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; state_in = d; bypass_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    // extra request while the result is held must be ignored
    in_valid = 1'b1; state_in = rnd128();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || state_out !== e || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold%0d: got vld=%b rdy=%b busy=%b %h want 1 0 1 %h",
                 i, out_valid, in_ready, busy, state_out, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    last_exp = e;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    logic [127:0] got [$];
    int           t [2];
    int           n_acc;
    a = rnd128();
    b = rnd128();
    n_acc = 0;
    t[0] = 0; t[1] = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; state_in = a; bypass_in = 1'b0;
    for (int i = 0; i < 40 && got.size() < 2; i++) begin
      if (out_valid && out_ready) got.push_back(state_out);
      if (in_valid && in_ready && n_acc < 2) begin
        t[n_acc] = cyc + 1;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 1) state_in = b;
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (n_acc !== 2) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d want 2", n_acc);
    end
    // accept edge, 4 column edges, HOLD handshake edge, then one IDLE cycle
    total++;
    if (t[1] - t[0] !== 6) begin
      bad++;
      $display("FAIL b2b_gap: got %0d want 6", t[1] - t[0]);
    end
    total++;
    if (got.size() !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 2", got.size());
    end else begin
      if (got[0] !== model_inv_mix(a, 1'b0)) begin
        bad++;
        $display("FAIL b2b_first: got %h want %h", got[0], model_inv_mix(a, 1'b0));
      end
      total++;
      if (got[1] !== model_inv_mix(b, 1'b0)) begin
        bad++;
        $display("FAIL b2b_second: got %h want %h", got[1], model_inv_mix(b, 1'b0));
      end
    end
    while (!in_ready && cyc < 100000) @(negedge clk);
    last_exp = model_inv_mix(b, 1'b0);
  endtask

  task automatic test_clear();
    logic [127:0] d, c;
    d = rnd128();
    c = rnd128();
    out_ready = 1'b1;
    in_valid = 1'b1; state_in = d; bypass_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (col_idx !== 2'd2) begin
      bad++;
      $display("FAIL clr_at_col: got %0d want 2", col_idx);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || col_idx !== 2'd0 || out_valid !== 1'b0
        || state_out !== last_exp) begin
      bad++;
      $display("FAIL clr_calc: got rdy=%b busy=%b col=%0d vld=%b %h want 1 0 0 0 %h",
               in_ready, busy, col_idx, out_valid, state_out, last_exp);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL clr_novalid%0d: got %b want 0", i, out_valid);
      end
    end
    // clear wins over a request in IDLE
    in_valid = 1'b1; state_in = c; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_idle_prio: got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || state_out !== model_inv_mix(c, 1'b0)) begin
      bad++;
      $display("FAIL clr_next: got vld=%b %h want 1 %h", out_valid, state_out, model_inv_mix(c, 1'b0));
    end
    // clear wins over out_ready in HOLD; result word is retained
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== model_inv_mix(c, 1'b0)) begin
      bad++;
      $display("FAIL clr_hold: got vld=%b rdy=%b %h want 0 1 %h",
               out_valid, in_ready, state_out, model_inv_mix(c, 1'b0));
    end
    last_exp = model_inv_mix(c, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [127:0] d, e;
    d = rnd128();
    e = rnd128();
    out_ready = 1'b1;
    in_valid = 1'b1; state_in = d; bypass_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || col_idx !== 2'd0
        || state_out !== 128'h0) begin
      bad++;
      $display("FAIL arst_immediate: got rdy=%b vld=%b busy=%b col=%0d %h want 1 0 0 0 0",
               in_ready, out_valid, busy, col_idx, state_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL arst_quiet%0d: got vld=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    in_valid = 1'b1; state_in = e; bypass_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || state_out !== model_inv_mix(e, 1'b0)) begin
      bad++;
      $display("FAIL arst_after: got vld=%b %h want 1 %h", out_valid, state_out, model_inv_mix(e, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
